// File: rtl/cache_arb_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM encoding and master ids.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b11,
    RESP = 2'b10
  } arb_state_e;

  localparam logic ARB_INST = 1'b0;
  localparam logic ARB_DATA = 1'b1;

endpackage

// File: rtl/cache_arb_select.sv
// Grant selection between instruction and data cache requests.
// CACHE_ARB_RR_EN selects round-robin tie-break; otherwise the data cache wins ties.
module cache_arb_select
  import cache_arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  input  logic fsm_idle,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = fsm_idle & (inst_req | data_req);

  always_comb begin
    grant_id = ARB_DATA;
    if (inst_req && !data_req) begin
      grant_id = ARB_INST;
    end else if (inst_req && data_req) begin
`ifdef CACHE_ARB_RR_EN
      grant_id = ~last_grant;
`else
      grant_id = ARB_DATA;
`endif
    end
  end

`ifndef CACHE_ARB_RR_EN
  // Fixed priority has no use for the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Merges instruction/data cache transactions onto one SRAM-like memory port,
// one transaction at a time. Optional macro: CACHE_ARB_RR_EN (round-robin ties).
module cache_mem_arbiter
  import cache_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  input  logic        data_cache_req,
  input  logic [31:0] data_cache_addr,
  input  logic [3:0]  data_cache_wen,
  input  logic [31:0] data_cache_wdata,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // Valid/ready: cache req is level-held until its one-cycle dok; mem_req is
  // held until mem_addr_ok, then the transaction completes on mem_data_ok.

  arb_state_e  state_q, state_d;
  logic        id_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        last_grant;
  logic        grant_valid;
  logic        grant_id;
  logic        done;

  cache_arb_select u_select (
    .inst_req    (inst_cache_req),
    .data_req    (data_cache_req),
    .last_grant  (last_grant),
    .fsm_idle    (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef CACHE_ARB_RR_EN
  logic last_grant_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          last_grant_q <= ARB_INST;
    else if (grant_valid) last_grant_q <= grant_id;
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_INST;
`endif

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (grant_valid) state_d = REQ;
      REQ: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            state_d = RESP;
            done    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          state_d = RESP;
          done    = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q    <= ARB_INST;
      wr_q    <= 1'b0;
      wstrb_q <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (grant_valid) begin
      id_q <= grant_id;
      if (grant_id == ARB_DATA) begin
        addr_q  <= data_cache_addr;
        wr_q    <= |data_cache_wen;
        wstrb_q <= data_cache_wen;
        wdata_q <= data_cache_wdata;
      end else begin
        addr_q  <= inst_cache_addr;
        wr_q    <= 1'b0;
        wstrb_q <= 4'h0;
        wdata_q <= 32'h0;
      end
    end
  end

  // Writes leave the requester's read data untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else if (done && !wr_q) begin
      if (id_q == ARB_DATA) data_rdata_q <= mem_rdata;
      else                  inst_rdata_q <= mem_rdata;
    end
  end

  assign mem_req          = (state_q == REQ);
  assign mem_wr           = wr_q;
  assign mem_wstrb        = wstrb_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign inst_cache_dok   = (state_q == RESP) && (id_q == ARB_INST);
  assign data_cache_dok   = (state_q == RESP) && (id_q == ARB_DATA);
  assign inst_cache_rdata = inst_rdata_q;
  assign data_cache_rdata = data_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (default or CACHE_ARB_RR_EN build).
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_cache_req = 1'b0;
  logic [31:0] inst_cache_addr = 32'h0;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        data_cache_req = 1'b0;
  logic [31:0] data_cache_addr = 32'h0;
  logic [3:0]  data_cache_wen = 4'h0;
  logic [31:0] data_cache_wdata = 32'h0;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;
  int inst_dok_cnt = 0;
  int data_dok_cnt = 0;
  int mem_txn_cnt = 0;
  logic [31:0] exp_q[$];

  cache_mem_arbiter dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .data_cache_req   (data_cache_req),
    .data_cache_addr  (data_cache_addr),
    .data_cache_wen   (data_cache_wen),
    .data_cache_wdata (data_cache_wdata),
    .data_cache_rdata (data_cache_rdata),
    .data_cache_dok   (data_cache_dok),
    .mem_req          (mem_req),
    .mem_wr           (mem_wr),
    .mem_wstrb        (mem_wstrb),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_addr_ok      (mem_addr_ok),
    .mem_data_ok      (mem_data_ok),
    .mem_rdata        (mem_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted memory address must match the next expected one.
  always @(negedge clk) begin
    if (inst_cache_dok) inst_dok_cnt++;
    if (data_cache_dok) data_dok_cnt++;
    if (mem_req && mem_addr_ok) begin
      mem_txn_cnt++;
      check("mem_txn_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("mem_addr", mem_addr, exp_q.pop_front());
    end
  end

  task automatic wait_mem_req(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!mem_req && cycles < 50);
    check("mem_req_timeout", 32'(mem_req), 32'd1);
  endtask

  // Memory-side driver: accept address after addr_dly stalls, data after data_dly more.
  task automatic serve(input string tag, input logic master, input int addr_dly,
                       input int data_dly, input logic [31:0] rd, input logic exp_wr,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                       input int exp_lat, input int exp_req_cycles, input bit release_req);
    int lat;
    int req_cycles;
    logic [31:0] old_rdata;
    old_rdata = (master == ARB_DATA) ? data_cache_rdata : inst_cache_rdata;
    wait_mem_req(lat);
    check({tag, "_wr"}, 32'(mem_wr), 32'(exp_wr));
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
    if (exp_wr) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    req_cycles = 0;
    for (int k = 0; k < addr_dly; k++) begin
      req_cycles += int'(mem_req);
      tick();
      lat++;
    end
    mem_addr_ok = 1'b1;
    mem_data_ok = (data_dly == 0);
    mem_rdata   = rd;
    req_cycles += int'(mem_req);
    tick();
    lat++;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    for (int k = 1; k <= data_dly; k++) begin
      mem_data_ok = (k == data_dly);
      req_cycles += int'(mem_req);
      tick();
      lat++;
    end
    mem_data_ok = 1'b0;
    mem_rdata   = 32'hEEEE_EEEE;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req_cycles));
    if (master == ARB_DATA) begin
      check({tag, "_dok"}, {inst_cache_dok, data_cache_dok}, 32'b01);
      check({tag, "_rdata"}, data_cache_rdata, exp_wr ? old_rdata : rd);
      if (release_req) data_cache_req = 1'b0;
    end else begin
      check({tag, "_dok"}, {inst_cache_dok, data_cache_dok}, 32'b10);
      check({tag, "_rdata"}, inst_cache_rdata, exp_wr ? old_rdata : rd);
      if (release_req) inst_cache_req = 1'b0;
    end
    tick();
    check({tag, "_dok_pulse"}, {inst_cache_dok, data_cache_dok}, 32'b00);
  endtask

  initial begin
    int d0;
    int i0;
    int t0;

    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", inst_cache_rdata | data_cache_rdata, 32'h0);
    check("rst_dok", {inst_cache_dok, data_cache_dok}, 32'b00);
    check("rst_state", 32'(dut.state_q), 32'(2'b00));
    resetn = 1'b1;
    tick();

    // 1: zero-wait data read
    d0 = data_dok_cnt;
    exp_q.push_back(32'h1FAF_0010);
    data_cache_addr = 32'h1FAF_0010;
    data_cache_wen  = 4'h0;
    data_cache_req  = 1'b1;
    serve("rd0", ARB_DATA, 0, 0, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
    check("rd0_dok_count", 32'(data_dok_cnt - d0), 32'd1);

    // 2: write with 3 addr stalls then 2 data stalls
    d0 = data_dok_cnt;
    exp_q.push_back(32'h1FAF_0020);
    data_cache_addr  = 32'h1FAF_0020;
    data_cache_wen   = 4'hF;
    data_cache_wdata = 32'h1234_5678;
    data_cache_req   = 1'b1;
    serve("wr0", ARB_DATA, 3, 2, 32'hCAFE_F00D, 1'b1, 4'hF, 32'h1234_5678, 7, 4, 1'b1);
    check("wr0_dok_count", 32'(data_dok_cnt - d0), 32'd1);
    check("wr0_rdata_kept", data_cache_rdata, 32'hDEAD_BEEF);

    // 3: simultaneous requests
    inst_cache_addr = 32'hBFC0_0000;
    data_cache_addr = 32'h8000_0100;
    data_cache_wen  = 4'h0;
`ifdef CACHE_ARB_RR_EN
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'h8000_0100);
    inst_cache_req = 1'b1;
    data_cache_req = 1'b1;
    serve("tie_first", ARB_INST, 0, 0, 32'h3333_4444, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
    serve("tie_second", ARB_DATA, 0, 0, 32'h1111_2222, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
`else
    exp_q.push_back(32'h8000_0100);
    exp_q.push_back(32'hBFC0_0000);
    inst_cache_req = 1'b1;
    data_cache_req = 1'b1;
    serve("tie_first", ARB_DATA, 0, 0, 32'h1111_2222, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
    serve("tie_second", ARB_INST, 0, 0, 32'h3333_4444, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
`endif
    check("tie_inst_rdata", inst_cache_rdata, 32'h3333_4444);
    check("tie_data_rdata", data_cache_rdata, 32'h1111_2222);

    // 4: req held across write-back then line load
    t0 = mem_txn_cnt;
    exp_q.push_back(32'h8000_0200);
    exp_q.push_back(32'h8000_0300);
    data_cache_addr  = 32'h8000_0200;
    data_cache_wen   = 4'hF;
    data_cache_wdata = 32'hA5A5_A5A5;
    data_cache_req   = 1'b1;
    serve("wb", ARB_DATA, 1, 1, 32'h0, 1'b1, 4'hF, 32'hA5A5_A5A5, 4, 2, 1'b0);
    data_cache_addr = 32'h8000_0300;
    data_cache_wen  = 4'h0;
    serve("ld", ARB_DATA, 0, 0, 32'h5A5A_0001, 1'b0, 4'h0, 32'h0, 2, 1, 1'b1);
    check("wb_ld_txn_count", 32'(mem_txn_cnt - t0), 32'd2);

    // 5: reset while waiting for data, then a late data_ok
    d0 = data_dok_cnt;
    exp_q.push_back(32'h8000_0400);
    data_cache_addr = 32'h8000_0400;
    data_cache_wen  = 4'h0;
    data_cache_req  = 1'b1;
    wait_mem_req(t0);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    tick();
    check("rst_mid_in_wait", 32'(dut.state_q), 32'(2'b11));
    resetn = 1'b0;
    data_cache_req = 1'b0;
    #1;
    check("rst_mid_state", 32'(dut.state_q), 32'(2'b00));
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h7777_7777;
    tick();
    mem_data_ok = 1'b0;
    repeat (2) tick();
    check("rst_late_dok", 32'(data_dok_cnt - d0), 32'd0);
    check("rst_late_state", 32'(dut.state_q), 32'(2'b00));
    check("rst_late_mem_req", 32'(mem_req), 32'd0);
    check("rst_late_rdata", data_cache_rdata, 32'h0);

    // 6: inst read, 5 address stalls, addr_ok and data_ok together
    i0 = inst_dok_cnt;
    exp_q.push_back(32'hBFC0_0040);
    inst_cache_addr = 32'hBFC0_0040;
    inst_cache_req  = 1'b1;
    serve("ird", ARB_INST, 5, 0, 32'h0BAD_F00D, 1'b0, 4'h0, 32'h0, 7, 6, 1'b1);
    check("ird_dok_count", 32'(inst_dok_cnt - i0), 32'd1);

    repeat (2) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Downstream neighbour of the instruction and data caches: merges the instruction-cache and data-cache miss/write-back requests onto the single SRAM-like memory port that feeds the AXI bridge. It accepts one cache transaction at a time, presents it to memory with an address/data handshake, and returns a one-cycle `*_dok` pulse with read data to the requesting cache. Cache-side requests are level-held until `dok`. The data cache may hold `req` high across back-to-back write-back then line-load.

## Interface
- No parameters; widths fixed at 32-bit address/data, 4-bit byte strobe.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `inst_cache_req` in 1: instruction cache request, held until `inst_cache_dok`.
- `inst_cache_addr` in 32: instruction read address.
- `inst_cache_rdata` out 32: read data, valid with `inst_cache_dok`.
- `inst_cache_dok` out 1: one-cycle completion pulse.
- `data_cache_req` in 1: data cache request, held until `data_cache_dok`.
- `data_cache_addr` in 32: data address.
- `data_cache_wen` in 4: byte write enables; 0 means read.
- `data_cache_wdata` in 32: write data.
- `data_cache_rdata` out 32: read data, valid with `data_cache_dok`.
- `data_cache_dok` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request, held until `mem_addr_ok`.
- `mem_wr` out 1: 1 = write.
- `mem_wstrb` out 4: byte strobes for writes, 0 for reads.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_addr_ok` in 1: address accepted.
- `mem_data_ok` in 1: read data valid or write done.
- `mem_rdata` in 32: memory read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Sample requests.
  - On grant, latch master id, addr, `wr = |wen`, wstrb and wdata into registers, then go to REQ.
  - Instruction requests latch `wr=0`, `wstrb=0`.
- REQ:
  - `mem_req=1`; all `mem_*` outputs come from the latched registers.
  - On `mem_addr_ok`: go to RESP if `mem_data_ok` is also high, else go to WAIT.
- WAIT: on `mem_data_ok`, go to RESP.
- Read data: `mem_rdata` is captured into the granted master's `rdata` register in the cycle that completes the transaction (the REQ→RESP or WAIT→RESP transition).
- RESP:
  - The granted master's `dok` is 1 for exactly this cycle.
  - For a write, `rdata` holds its previous value.
  - Unconditionally go to IDLE.
- IDLE never samples in the same cycle as `dok`, so a req left over from the completed transaction is never re-granted. A req still high in IDLE is a new transaction.
- Grant on simultaneous requests: fixed data-cache priority; see Configuration for the alternative.
- A master dropping `req` mid-transaction: ignored; the latched transaction completes and `dok` still pulses.
- `mem_addr_ok` / `mem_data_ok` outside REQ/WAIT: ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`, `mem_wr`, `inst_cache_dok`, `data_cache_dok` = 0.
  - `mem_wstrb` = 0.
  - `mem_addr`, `mem_wdata`, both `rdata` = 0.
  - `last_grant` = inst.
- Latency with zero-wait memory (`addr_ok` and `data_ok` in the first REQ cycle): req sampled at cycle 0, `mem_req` high at cycle 1, `dok` at cycle 2.
- Each wait cycle on either handshake adds 1.
- All outputs are registered or decoded from state/latched registers; no combinational path from any cache-side input to `mem_*`.
- Reset mid-transaction: immediate return to IDLE, `dok` never pulses, and a late `mem_data_ok` is ignored. The bridge must be reset together with this block.

## Configuration
- `CACHE_ARB_RR_EN` defined:
  - Round-robin grant: on simultaneous requests, grant the master not in `last_grant`.
  - `last_grant` updates on every grant.
- Undefined: the data cache always wins ties; `last_grant` is absent.
- A single requester is granted immediately in both modes.

## Structure
- Shared package `cache_arb_pkg` holds:
  - the state encoding (IDLE=2'b00, REQ=2'b01, WAIT=2'b11, RESP=2'b10);
  - master id constants `ARB_INST=1'b0`, `ARB_DATA=1'b1`.
- One sub-module, `cache_arb_select`: grant logic.
  - Inputs: both reqs, `last_grant`, FSM-idle flag.
  - Outputs: `grant_valid` and `grant_id`.
  - Its `CACHE_ARB_RR_EN` variant is confined there.

## Test plan
- Single data read at 0x1FAF_0010, zero-wait memory, `mem_rdata`=0xDEADBEEF -> `mem_req` high for 1 cycle with `mem_wr`=0; `data_cache_dok` pulses 2 cycles after req with `data_cache_rdata`=0xDEADBEEF.
- Data write `wen`=4'b1111, wdata=0x12345678, `addr_ok` delayed 3 cycles, `data_ok` 2 after that -> `mem_wstrb`=4'hF, `mem_req` held 4 cycles; `dok` pulses once; `data_cache_rdata` unchanged.
- Both caches request in the same cycle (inst 0xBFC0_0000, data 0x8000_0100):
  - without `CACHE_ARB_RR_EN` -> data served first, then inst;
  - with `CACHE_ARB_RR_EN` and `last_grant`=data -> inst served first.
- Data req held continuously across write-back then load (address changes the cycle after `dok`) -> exactly two memory transactions, the second with the new address and `mem_wr`=0.
- `resetn` asserted while in WAIT, then `mem_data_ok` arrives after release -> FSM in IDLE, no `dok`, `mem_req`=0.
- Inst read with `addr_ok` and `data_ok` in the same cycle after 5 idle `addr_ok` cycles -> REQ goes directly to RESP; `inst_cache_dok` pulses once with the correct rdata.
